// File: rtl/branch_resolve_checker.sv
// Branch resolve checker: holds in-flight conditional-branch predictions in
// program order, compares each against its commit-time outcome, reports the
// result to the predictor and flushes/redirects the front end on a mispredict.
module branch_resolve_checker #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        is_correction,
  output logic [31:0] pc_correct,
  output logic        is_correct,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        order_err
);

  localparam int CW = DEPTH_LOG2 + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t state, state_nxt;

  logic [31:0]           pc_mem     [DEPTH];
  logic                  taken_mem  [DEPTH];
  logic [31:0]           target_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head, tail;
  logic [CW-1:0]         count;

  logic        in_run, q_empty, q_full;
  logic        do_res, mispredict, enq, pop;
  logic [31:0] head_pc, head_target;
  logic        head_taken;

  assign in_run      = (state == RUN);
  assign q_empty     = (count == '0);
  assign q_full      = (count == CW'(DEPTH));
  assign head_pc     = pc_mem[head];
  assign head_taken  = taken_mem[head];
  assign head_target = target_mem[head];

  // Ready only from registered state so fetch never sees a comb path from resolve.
  assign pred_ready = !rst && in_run && !q_full;

  assign do_res     = in_run && res_valid && !q_empty;
  assign mispredict = (res_taken != head_taken) ||
                      (res_taken && (res_target != head_target));
  // A mispredict squashes everything younger, including this cycle's fetch.
  assign enq        = pred_valid && pred_ready && !(do_res && mispredict);
  assign pop        = do_res && !mispredict;

  // Next-state: a mispredict spends exactly one cycle in FLUSH.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (do_res && mispredict) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]     <= pred_pc;
      taken_mem[tail]  <= pred_taken;
      target_mem[tail] <= pred_target;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (do_res && mispredict) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  // Registered predictor update, flush/redirect and sticky ordering error.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_correction <= 1'b0;
      pc_correct    <= '0;
      is_correct    <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      order_err     <= 1'b0;
    end else begin
      is_correction <= do_res;
      flush         <= do_res && mispredict;
      if (do_res) begin
        pc_correct <= head_pc;
        is_correct <= !mispredict;
      end
      if (do_res && mispredict)
        redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
      if (in_run && res_valid && (q_empty || (res_pc != head_pc)))
        order_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_checker.sv
// Bench for branch_resolve_checker: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the branch tracker.
module tb_branch_resolve_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [31:0] pred_pc = '0, pred_target = '0;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] res_pc = '0, res_target = '0;
  logic        pred_ready, is_correction, is_correct, flush, order_err;
  logic [31:0] pc_correct, redirect_pc;

  always #5 clk = ~clk;

  branch_resolve_checker #(.DEPTH(8), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .is_correction(is_correction),
    .pc_correct(pc_correct), .is_correct(is_correct), .flush(flush),
    .redirect_pc(redirect_pc), .order_err(order_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
  } ent_t;

  // reference model state
  ent_t        q[$];
  bit          m_flush;
  logic        e_corr, e_isc, e_flush, e_oe;
  logic [31:0] e_pcc, e_redir;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus; check ready before the edge and registered
  // outputs after it against the model.
  task automatic step(input bit r,
                      input bit pv, input logic [31:0] ppc, input bit pt, input logic [31:0] ptg,
                      input bit rv, input logic [31:0] rpc, input bit rt, input logic [31:0] rtg);
    bit   rdy, mis;
    ent_t h;
    @(negedge clk);
    rst = r; pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
    #1;
    rdy = !r && !m_flush && (q.size() != 8);
    chk("pred_ready", pred_ready, rdy);
    @(posedge clk);
    e_corr = 1'b0; e_flush = 1'b0;
    if (r) begin
      q.delete(); m_flush = 0;
      e_isc = 0; e_pcc = '0; e_redir = '0; e_oe = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      mis = 0;
      if (rv) begin
        if (q.size() == 0) e_oe = 1'b1;
        else begin
          h = q[0];
          if (rpc != h.pc) e_oe = 1'b1;
          mis = (rt != h.tk) || (rt && rtg != h.tg);
          e_corr = 1'b1; e_pcc = h.pc; e_isc = !mis;
          if (mis) begin
            q.delete(); m_flush = 1; e_flush = 1'b1;
            e_redir = rt ? rtg : rpc + 32'd4;
          end else void'(q.pop_front());
        end
      end
      if (pv && rdy && !mis) q.push_back('{ppc, pt, ptg});
    end
    #1;
    chk("is_correction", is_correction, e_corr);
    chk("pc_correct", pc_correct, e_pcc);
    chk("is_correct", is_correct, e_isc);
    chk("flush", flush, e_flush);
    chk("redirect_pc", redirect_pc, e_redir);
    chk("order_err", order_err, e_oe);
  endtask

  task automatic idle();                          step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic reset1();                        step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic enq(input logic [31:0] pc, input bit t, input logic [31:0] tg);
    step(0, 1, pc, t, tg, 0, 0, 0, 0);
  endtask
  task automatic res(input logic [31:0] pc, input bit t, input logic [31:0] tg);
    step(0, 0, 0, 0, 0, 1, pc, t, tg);
  endtask

  initial begin
    ent_t h;
    bit   rv, rt, mk;
    logic [31:0] rpc, rtg;

    // reset state
    reset1(); reset1();
    chk("rst_order_err", order_err, 1'b0);
    chk("rst_redirect", redirect_pc, 32'h0);

    // basic correct resolve
    enq(32'h100, 0, 0); enq(32'h200, 0, 0); enq(32'h300, 0, 0);
    res(32'h100, 0, 0);
    chk("basic_corr", is_correction, 1'b1);
    chk("basic_pcc", pc_correct, 32'h100);
    chk("basic_isc", is_correct, 1'b1);
    res(32'h200, 0, 0); res(32'h300, 0, 0); idle();

    // fill, full-cycle enqueue dropped during pop, then wrap
    reset1();
    for (int i = 0; i < 8; i++) enq(32'h1000 + 32'(i) * 4, 0, 0);
    step(0, 1, 32'hdead, 0, 0, 1, 32'h1000, 0, 0);
    chk("full_drop_ready", pred_ready, 1'b1);
    for (int i = 0; i < 3; i++) enq(32'h2000 + 32'(i) * 4, 1, 32'h3000);
    for (int i = 1; i < 8; i++) res(32'h1000 + 32'(i) * 4, 0, 0);
    for (int i = 0; i < 3; i++) res(32'h2000 + 32'(i) * 4, 1, 32'h3000);

    // mispredict: predicted not-taken, actually taken
    reset1();
    enq(32'h40, 0, 0); enq(32'h44, 0, 0);
    res(32'h40, 1, 32'h80);
    chk("mis_isc", is_correct, 1'b0);
    chk("mis_redir", redirect_pc, 32'h80);
    chk("mis_flush", flush, 1'b1);
    enq(32'h60, 0, 0); enq(32'h64, 0, 0);

    // wrong target, then taken-predicted but not-taken outcome
    reset1();
    enq(32'h40, 1, 32'h80); res(32'h40, 1, 32'h90);
    chk("tgt_redir", redirect_pc, 32'h90);
    idle();
    enq(32'h40, 1, 32'h80); res(32'h40, 0, 0);
    chk("nt_redir", redirect_pc, 32'h44);
    idle();
    enq(32'hfffffffc, 0, 0); res(32'hfffffffc, 1, 32'h10);
    idle();
    enq(32'hfffffffc, 1, 32'h10); res(32'hfffffffc, 0, 0);
    chk("wrap_redir", redirect_pc, 32'h0);
    idle();

    // ordering errors
    reset1();
    res(32'h500, 0, 0);
    chk("empty_oe", order_err, 1'b1);
    idle();
    enq(32'h400, 0, 0); res(32'h500, 0, 0);
    chk("pc_oe_pcc", pc_correct, 32'h400);
    step(0, 1, 32'h600, 0, 0, 1, 32'h600, 0, 0);  // enqueue into empty with resolve

    // reset during the flush cycle
    reset1();
    enq(32'h40, 0, 0); res(32'h40, 1, 32'h80);
    reset1();
    chk("rst_flush", flush, 1'b0);
    idle(); enq(32'h50, 0, 0); res(32'h50, 0, 0);

    // random traffic
    reset1();
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 2) == 0);
      rpc = {$urandom_range(0, 255), 2'b00};
      rt = $urandom_range(0, 1); rtg = {$urandom_range(0, 63), 2'b00};
      if (q.size() > 0 && !m_flush) begin
        h = q[0];
        if ($urandom_range(0, 31) != 0) rpc = h.pc;
        mk = ($urandom_range(0, 3) != 0);
        if (mk) begin rt = h.tk; rtg = h.tk ? h.tg : rtg; end
      end
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 2) != 0), {$urandom_range(0, 255), 2'b00},
           $urandom_range(0, 1), {$urandom_range(0, 63), 2'b00},
           rv, rpc, rt, rtg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_checker.md
Name: branch_resolve_checker

Overview:
- Tracks every conditional-branch prediction issued at fetch in an in-order queue.
- Compares each queued prediction against the branch outcome when the branch resolves at commit.
- Drives the correction interface of the branch predictor (`is_correction` / `pc_correct` / `is_correct`).
- On a misprediction, raises a one-cycle front-end flush with the redirect PC and discards all younger queued predictions.

Parameters:
- DEPTH, 8, number of in-flight predictions held; must be a power of two.
- DEPTH_LOG2, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- pred_valid  input  1  fetch issues a branch prediction this cycle
- pred_pc  input  32  PC of the predicted branch
- pred_taken  input  1  predicted direction
- pred_target  input  32  predicted taken target
- pred_ready  output  1  queue can accept a prediction
- res_valid  input  1  oldest in-flight branch resolves this cycle (program order)
- res_pc  input  32  PC of the resolving branch
- res_taken  input  1  actual direction
- res_target  input  32  actual taken target
- is_correction  output  1  predictor update strobe
- pc_correct  output  32  PC of the branch being corrected
- is_correct  output  1  1 = prediction was right; predictor strengthens its state. 0 = prediction was wrong; predictor weakens or flips.
- flush  output  1  front-end flush strobe
- redirect_pc  output  32  fetch restart address, valid when flush=1
- order_err  output  1  sticky; resolution PC did not match the queue head, or resolution arrived while empty

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, taken, target}.
  - head and tail are DEPTH_LOG2-bit pointers that wrap modulo DEPTH.
  - count is DEPTH_LOG2+1 bits.
- Reset: head=tail=count=0, state=RUN. All outputs 0: pred_ready=0 during reset; redirect_pc=0; pc_correct=0; order_err=0.
- State machine: RUN and FLUSH.
- pred_ready = (state==RUN) && (count != DEPTH). It is combinational from registered state and does not depend on a same-cycle resolution.
- Enqueue (RUN only): when pred_valid && pred_ready, write the entry at tail and advance tail. pred_valid while pred_ready=0 is dropped; fetch must hold.
- Resolve (RUN only): when res_valid && count!=0, take the head entry.
  - mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target).
  - If res_pc != head.pc, set order_err. The comparison still proceeds using the head entry.
  - Next cycle (registered, 1-cycle latency): is_correction=1, pc_correct=head.pc, is_correct=!mispredict.
  - Correct prediction: pop the head and go to the next resolution; no flush.
  - Mispredict: at the same edge, clear the queue (head=tail, count=0), drop any same-cycle enqueue, and go to FLUSH.
- FLUSH: lasts exactly one cycle.
  - flush=1 and redirect_pc = res_taken ? res_target : res_pc+4, latched from the resolving cycle; +4 wraps mod 2^32.
  - pred_ready=0, and res_valid is ignored.
  - Then return to RUN.
- Simultaneous enqueue and correct resolve: both occur and count is unchanged. When full, pred_ready stays 0 that cycle even though a pop occurs.
- Simultaneous enqueue into an empty queue with res_valid: the resolution is treated as empty, the enqueue proceeds, and order_err is set.
- res_valid while empty: no correction strobe; set order_err.
- Strobes: is_correction and flush are single-cycle pulses. They are 0 in every cycle without a resolution or flush. pc_correct and redirect_pc hold their last value.
- Reset mid-operation: asserting rst on any edge returns to the reset state. Any pending FLUSH is cancelled and queued entries are discarded.

Test Plan:
- Reset, then 3 enqueues (pc 0x100/0x200/0x300, all taken=0), then resolve 0x100 not-taken → next cycle is_correction=1, pc_correct=0x100, is_correct=1, flush=0; count=2.
- Fill 8 entries → pred_ready=0. In a cycle with pred_valid=1 plus a correct resolve, the enqueue is dropped and count=7. The next cycle pred_ready=1, and pointers wrap correctly on the following enqueues.
- Queue holds pc 0x40 predicted not-taken; resolve res_taken=1, res_target=0x80 → is_correct=0, flush=1 with redirect_pc=0x80, queue emptied. pred_ready=0 during the FLUSH cycle and 1 after.
- Queue holds pc 0x40 predicted taken→0x80; resolve taken→0x90 → is_correct=0, redirect_pc=0x90. Resolve not-taken → redirect_pc=0x44.
- res_valid with the queue empty → no is_correction pulse, order_err=1 and stays set. A resolve with res_pc=0x500 against head 0x400 → order_err=1, correction reported with pc_correct=0x400.
- Assert rst during the FLUSH cycle → the next cycle has flush=0, count=0, order_err=0, state RUN.
